// File: rtl/qsn_layer_scheduler_if.sv
// QSN command channel between the layer scheduler and the shift network.
//   qsn_valid      scheduler -> QSN  command valid
//   qsn_ready      QSN -> scheduler  command accepted
//   qsn_shift      scheduler -> QSN  cyclic shift select
//   qsn_idx        scheduler -> QSN  table index of the command
//   qsn_layer_end  scheduler -> QSN  command closes its layer
//   qsn_iter       scheduler -> QSN  0-based decoding iteration
interface qsn_layer_scheduler_if #(
  parameter int SHIFT_W = 2,
  parameter int ADDR_W  = 3,
  parameter int ITER_W  = 4
);
  logic               qsn_valid;
  logic               qsn_ready;
  logic [SHIFT_W-1:0] qsn_shift;
  logic [ADDR_W-1:0]  qsn_idx;
  logic               qsn_layer_end;
  logic [ITER_W-1:0]  qsn_iter;

  modport master (
    output qsn_valid, qsn_shift, qsn_idx, qsn_layer_end, qsn_iter,
    input  qsn_ready
  );

  modport slave (
    input  qsn_valid, qsn_shift, qsn_idx, qsn_layer_end, qsn_iter,
    output qsn_ready
  );
endinterface

// File: rtl/qsn_layer_scheduler.sv
// QSN layer scheduler: holds a programmable table of per-block shift values
// and replays it to the quasi-cyclic shift network for num_iter iterations,
// inserting one bubble cycle at every layer boundary.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cfg_we_i            table write strobe (ignored while busy)
//   cfg_addr_i          table write index
//   cfg_shift_i         shift value written
//   cfg_last_i          entry closes a layer
//   cfg_len_i           index of final table entry, captured at start
//   num_iter_i          iterations to run, captured at start
//   start_i, abort_i    run control; abort has priority
//   busy_o, done_o      status; done is a one-cycle completion pulse
//   qsn                 command channel (master side)
module qsn_layer_scheduler #(
  parameter int LIFT    = 4,
  parameter int SHIFT_W = 2,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int ITER_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we_i,
  input  logic [ADDR_W-1:0]      cfg_addr_i,
  input  logic [SHIFT_W-1:0]     cfg_shift_i,
  input  logic                   cfg_last_i,
  input  logic [ADDR_W-1:0]      cfg_len_i,
  input  logic [ITER_W-1:0]      num_iter_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  qsn_layer_scheduler_if.master  qsn
);

  if (LIFT != (1 << SHIFT_W)) begin : g_lift_check
    $error("LIFT must equal 2**SHIFT_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DONE} state_t;

  logic [SHIFT_W-1:0] tbl_shift_q [DEPTH];
  logic               tbl_last_q  [DEPTH];

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d, len_q, len_d;
  logic [ITER_W-1:0]  iter_q, iter_d, niter_q, niter_d;

  logic               busy_q, done_q, valid_q, lend_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [ITER_W-1:0]  qiter_q;

  logic               hs;

  assign hs = valid_q & qsn.qsn_ready;

  // Table writes are locked out for the whole run so the replay is coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_shift_q[i] <= '0;
        tbl_last_q[i]  <= 1'b0;
      end
    end else if (cfg_we_i && !busy_q) begin
      tbl_shift_q[cfg_addr_i] <= cfg_shift_i;
      tbl_last_q[cfg_addr_i]  <= cfg_last_i;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    iter_d  = iter_q;
    len_d   = len_q;
    niter_d = niter_q;
    if (abort_i) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      iter_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            len_d   = cfg_len_i;
            niter_d = num_iter_i;
            ptr_d   = '0;
            iter_d  = '0;
            // A zero-iteration run passes through GAP so done still lands
            // two cycles after start, without issuing any command.
            state_d = (num_iter_i == '0) ? S_GAP : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (hs) begin
            if (ptr_q == len_q) begin
              if (iter_q == niter_q - ITER_W'(1)) begin
                state_d = S_DONE;
              end else begin
                ptr_d   = '0;
                iter_d  = iter_q + ITER_W'(1);
                state_d = S_GAP;
              end
            end else begin
              ptr_d   = ptr_q + ADDR_W'(1);
              state_d = tbl_last_q[ptr_q] ? S_GAP : S_ISSUE;
            end
          end
        end
        S_GAP: state_d = (niter_q == '0) ? S_DONE : S_ISSUE;
        S_DONE: begin
          state_d = S_IDLE;
          ptr_d   = '0;
          iter_d  = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state, so the command shown in a
  // cycle is exactly the one the FSM sits on; command fields read 0 when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      iter_q  <= '0;
      len_q   <= '0;
      niter_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      lend_q  <= 1'b0;
      shift_q <= '0;
      idx_q   <= '0;
      qiter_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      iter_q  <= iter_d;
      len_q   <= len_d;
      niter_q <= niter_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      valid_q <= (state_d == S_ISSUE);
      if (state_d == S_ISSUE) begin
        shift_q <= tbl_shift_q[ptr_d];
        idx_q   <= ptr_d;
        qiter_q <= iter_d;
        lend_q  <= tbl_last_q[ptr_d] | (ptr_d == len_d);
      end else begin
        shift_q <= '0;
        idx_q   <= '0;
        qiter_q <= '0;
        lend_q  <= 1'b0;
      end
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign qsn.qsn_valid     = valid_q;
  assign qsn.qsn_shift     = shift_q;
  assign qsn.qsn_idx       = idx_q;
  assign qsn.qsn_layer_end = lend_q;
  assign qsn.qsn_iter      = qiter_q;

endmodule

// File: tb/tb_qsn_layer_scheduler.sv
module tb_qsn_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [1:0] cfg_shift = '0;
  logic       cfg_last = 1'b0;
  logic [2:0] cfg_len = 3'd3;
  logic [3:0] num_iter = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  qsn_layer_scheduler_if #(.SHIFT_W(2), .ADDR_W(3), .ITER_W(4)) bus ();

  qsn_layer_scheduler #(
    .LIFT(4), .SHIFT_W(2), .DEPTH(8), .ADDR_W(3), .ITER_W(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_shift_i(cfg_shift),
    .cfg_last_i (cfg_last),
    .cfg_len_i  (cfg_len),
    .num_iter_i (num_iter),
    .start_i    (start),
    .abort_i    (abort),
    .busy_o     (busy),
    .done_o     (done),
    .qsn        (bus)
  );

  // {valid, shift, idx, layer_end, iter, done, busy}
  wire [12:0] obs = {bus.qsn_valid, bus.qsn_shift, bus.qsn_idx, bus.qsn_layer_end,
                     bus.qsn_iter, done, busy};

  typedef struct {
    logic       st;
    logic       ab;
    logic       rd;
    logic [3:0] n;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] pk(input logic v, input logic [1:0] sh, input logic [2:0] ix,
                                     input logic le, input logic [3:0] it, input logic dn,
                                     input logic bz);
    return {v, sh, ix, le, it, dn, bz};
  endfunction

  // Row expecting a valid command; inputs ready/abort applied that cycle.
  task automatic cmd(input logic rd, input logic ab, input logic [1:0] sh, input logic [2:0] ix,
                     input logic le, input logic [3:0] it);
    vec_t v;
    v = '{1'b0, ab, rd, 4'd1, pk(1'b1, sh, ix, le, it, 1'b0, 1'b1)};
    vecs.push_back(v);
  endtask

  // Row expecting no command; start/abort/num_iter applied that cycle.
  task automatic nc(input logic st, input logic ab, input logic [3:0] n, input logic dn,
                    input logic bz);
    vec_t v;
    v = '{st, ab, 1'b1, n, pk(1'b0, 2'd0, 3'd0, 1'b0, 4'd0, dn, bz)};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [1:0] s, input logic l);
    cfg_we = 1'b1; cfg_addr = a; cfg_shift = s; cfg_last = l;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    bus.qsn_ready = 1'b1;
    #1;
    chk("reset_state", obs, 13'd0);
    tick();
    rst_n = 1'b1;
    tick();

    wr(3'd0, 2'd1, 1'b0);
    wr(3'd1, 2'd3, 1'b1);
    wr(3'd2, 2'd0, 1'b0);
    wr(3'd3, 2'd2, 1'b0);

    // one iteration
    nc(1, 0, 4'd1, 0, 0);
    cmd(1, 0, 2'd1, 3'd0, 0, 4'd0);
    cmd(1, 0, 2'd3, 3'd1, 1, 4'd0);
    nc(0, 0, 4'd1, 0, 1);
    cmd(1, 0, 2'd0, 3'd2, 0, 4'd0);
    cmd(1, 0, 2'd2, 3'd3, 1, 4'd0);
    nc(0, 0, 4'd1, 1, 1);
    // two iterations
    nc(1, 0, 4'd2, 0, 0);
    cmd(1, 0, 2'd1, 3'd0, 0, 4'd0);
    cmd(1, 0, 2'd3, 3'd1, 1, 4'd0);
    nc(0, 0, 4'd2, 0, 1);
    cmd(1, 0, 2'd0, 3'd2, 0, 4'd0);
    cmd(1, 0, 2'd2, 3'd3, 1, 4'd0);
    nc(0, 0, 4'd2, 0, 1);
    cmd(1, 0, 2'd1, 3'd0, 0, 4'd1);
    cmd(1, 0, 2'd3, 3'd1, 1, 4'd1);
    nc(0, 0, 4'd2, 0, 1);
    cmd(1, 0, 2'd0, 3'd2, 0, 4'd1);
    cmd(1, 0, 2'd2, 3'd3, 1, 4'd1);
    nc(0, 0, 4'd2, 1, 1);
    // ready held low on idx2 for three cycles
    nc(1, 0, 4'd1, 0, 0);
    cmd(1, 0, 2'd1, 3'd0, 0, 4'd0);
    cmd(1, 0, 2'd3, 3'd1, 1, 4'd0);
    nc(0, 0, 4'd1, 0, 1);
    cmd(0, 0, 2'd0, 3'd2, 0, 4'd0);
    cmd(0, 0, 2'd0, 3'd2, 0, 4'd0);
    cmd(0, 0, 2'd0, 3'd2, 0, 4'd0);
    cmd(1, 0, 2'd0, 3'd2, 0, 4'd0);
    cmd(1, 0, 2'd2, 3'd3, 1, 4'd0);
    nc(0, 0, 4'd1, 1, 1);
    // start together with abort in IDLE stays idle
    nc(1, 1, 4'd1, 0, 0);
    // abort on the idx2 handshake, then restart, then abort a stalled command
    nc(1, 0, 4'd1, 0, 0);
    cmd(1, 0, 2'd1, 3'd0, 0, 4'd0);
    cmd(1, 0, 2'd3, 3'd1, 1, 4'd0);
    nc(0, 0, 4'd1, 0, 1);
    cmd(1, 1, 2'd0, 3'd2, 0, 4'd0);
    nc(1, 0, 4'd1, 0, 0);
    cmd(0, 1, 2'd1, 3'd0, 0, 4'd0);
    // zero iterations: no command, done two cycles after start
    nc(1, 0, 4'd0, 0, 0);
    nc(0, 0, 4'd0, 0, 1);
    nc(0, 0, 4'd0, 1, 1);
    nc(0, 0, 4'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st;
      abort = vecs[i].ab;
      bus.qsn_ready = vecs[i].rd;
      num_iter = vecs[i].n;
      chk($sformatf("vec%0d", i), obs, vecs[i].exp);
      tick();
    end
    start = 1'b0; abort = 1'b0; bus.qsn_ready = 1'b1;

    // table write while busy is ignored
    begin
      int n;
      num_iter = 4'd1; start = 1'b1; bus.qsn_ready = 1'b0;
      tick();
      start = 1'b0;
      chk("stall_cmd", obs, pk(1, 2'd1, 3'd0, 0, 4'd0, 0, 1));
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_shift = 2'd2; cfg_last = 1'b1;
      tick();
      cfg_we = 1'b0;
      chk("we_busy_hold", obs, pk(1, 2'd1, 3'd0, 0, 4'd0, 0, 1));
      bus.qsn_ready = 1'b1;
      n = 0;
      while (!done && n < 30) begin
        tick();
        n++;
      end
      chk("we_busy_done", {12'd0, done}, 13'd1);
      tick();
      start = 1'b1; bus.qsn_ready = 1'b0;
      tick();
      start = 1'b0;
      chk("table_unchanged", obs, pk(1, 2'd1, 3'd0, 0, 4'd0, 0, 1));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle", obs, 13'd0);
    end

    // asynchronous reset mid-run clears outputs and the table
    bus.qsn_ready = 1'b1; num_iter = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_reset", obs, pk(1, 2'd3, 3'd1, 1, 4'd0, 0, 1));
    #1 rst_n = 1'b0;
    #1 chk("async_reset", obs, 13'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_idx0", obs, pk(1, 2'd0, 3'd0, 0, 4'd0, 0, 1));
    tick();
    chk("post_rst_idx1", obs, pk(1, 2'd0, 3'd1, 0, 4'd0, 0, 1));
    tick();
    tick();
    chk("post_rst_idx3", obs, pk(1, 2'd0, 3'd3, 1, 4'd0, 0, 1));
    tick();
    chk("post_rst_done", obs, pk(0, 2'd0, 3'd0, 0, 4'd0, 1, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
